timer_arbiter: RTL and testbench
================================

// Module: timer_arbiter
// PURPOSE
//  Shares one delay-timing resource (prescaler + period counter) among N_REQ requesters.
//  Typical requesters: hunger tick, sleep timer, animation hold, sound hold.
//  Round-robin grant; one timed interval of dur*TICK_MAX clk cycles per grant.
//  Owner sees active high during the interval and a 1-cycle done pulse at its end.
// PARAMETERS
//  N_REQ    4          number of requesters (>=2)
//  CNT_W    26         prescaler width
//  TICK_MAX 50000000   clk cycles per base period (1 s @50 MHz); 1 <= TICK_MAX < 2**CNT_W
//  DUR_W    4          width of per-requester duration field (unit = base periods)
// PORTS
//  clk     in   1            system clock, all logic on posedge
//  rst     in   1            async, active-high reset
//  req     in   N_REQ        level request per requester, sampled only in IDLE
//  dur     in   N_REQ*DUR_W  durations; requester i uses dur[i*DUR_W +: DUR_W]
//  grant   out  N_REQ        one-hot current owner; 0 when IDLE
//  active  out  1            high while the owner's interval is counting
//  done    out  N_REQ        1-cycle pulse to the owner at interval end
//  busy    out  1            high in COUNT and DONE
// BEHAVIOUR
//  Reset (async): state=IDLE; grant, active, done, busy = 0; prescaler and period counter = 0.
//   rr pointer last=N_REQ-1, so requester 0 has highest priority first.
//  IDLE
//   - Any req bit set: choose first set bit searching last+1, last+2, ... (mod N_REQ).
//   - Latch that requester's dur and its index into owner.
//   - Next edge: state=COUNT, grant=onehot(owner).
//   - Latency: req seen high at edge k -> grant/active high from cycle k+1.
//  COUNT
//   - active=1; interval length = dur_eff*TICK_MAX cycles, dur_eff = (dur==0) ? 1 : dur.
//   - Prescaler 0..TICK_MAX-1, wraps to 0; each wrap decrements the period counter.
//   - On the final cycle (last period, prescaler=TICK_MAX-1): next state=DONE.
//   - req/dur changes during COUNT are ignored; the latched dur is used.
//  DONE (exactly 1 cycle)
//   - done[owner]=1, active=0, grant held; last<=owner; next state=IDLE.
//  IDLE after DONE
//   - grant=0. A req still high is a new request, arbitrated normally (rr gives others priority).
//   - Requesters drop req the cycle after done to avoid re-trigger.
//  Simultaneous requests: one grant per interval, none starved; max wait (N_REQ-1) intervals.
//  Widths: prescaler CNT_W bits; period counter DUR_W bits; no overflow for legal params.
//  Reset mid-interval: immediate return to reset values; no done pulse issued.
//  done and grant are registered outputs; active and busy are state decodes.
// CONFIGURATION
//  TIMER_ARB_ABORT_EN defined
//   - In COUNT, if req[owner] is low at an edge: next state=IDLE, active=0, grant=0.
//   - No done pulse; last<=owner (abort counts as a served turn).
//  TIMER_ARB_ABORT_EN undefined
//   - req is ignored outside IDLE; every granted interval runs to completion and pulses done.
// TESTING  (bench params: N_REQ=4, TICK_MAX=4, DUR_W=3, CNT_W=3)
//  1 Reset: rst=1 at any point -> grant=0000, done=0000, active=0, busy=0 same cycle.
//  2 Single request: req=0001, dur0=2, first seen at edge 0
//    -> grant=0001 and active=1 cycles 1-8 (8 cycles)
//    -> done=0001 only in cycle 9; grant=0000 in cycle 10.
//  3 Contention: req=1010 held, all dur=1, after reset
//    -> owner order 1,3,1,3; 4 active cycles each; one idle cycle between intervals.
//  4 Zero duration: req=0100, dur2=0 -> active exactly 4 cycles, then done=0100 one cycle.
//  5 Reset mid-interval: rst pulsed at cycle 5 of test 2
//    -> outputs 0 immediately, no done; next req0 restarts with full 8-cycle interval.
//  6 Abort: req0 dur=3, drop req0 in cycle 3
//    -> with TIMER_ARB_ABORT_EN: active=0 and grant=0 from cycle 4, done never pulses.
//    -> without: active runs 12 cycles, then done=0001.

Source files
------------

// File: rtl/timer_arbiter.sv
// timer_arbiter: one prescaler/period-counter pair shared among N_REQ requesters.
// A round-robin pick in IDLE grants one requester a single interval of
// dur*TICK_MAX clk cycles (a duration of 0 counts as 1). The owner sees
// active during the interval and a one-cycle done pulse when it ends.
// Optional feature macro: TIMER_ARB_ABORT_EN. When it is defined, the
// owner dropping its req during COUNT ends the interval early, with no done
// pulse.
module timer_arbiter #(
  parameter int N_REQ    = 4,
  parameter int CNT_W    = 26,
  parameter int TICK_MAX = 50000000,
  parameter int DUR_W    = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*DUR_W-1:0] dur_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic                   active_o,
  output logic [N_REQ-1:0]       done_o,
  output logic                   busy_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICK_MAX - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q,  last_d;
  logic [DUR_W-1:0]   per_q,   per_d;
  logic [CNT_W-1:0]   pre_q,   pre_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q,  done_d;

  logic               sel_found_s;
  logic [IDX_W-1:0]   sel_idx_s;
  logic [IDX_W-1:0]   cand_s;
  logic               hit_s;
  logic [DUR_W-1:0]   sel_dur_s;
  logic               abort_s;

  // Round-robin search: first set req bit starting just after the last owner.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = last_q;
    cand_s      = last_q;
    hit_s       = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s      = IDX_W'((int'(last_q) + k) % N_REQ);
      hit_s       = !sel_found_s && req_i[cand_s];
      sel_idx_s   = hit_s ? cand_s : sel_idx_s;
      sel_found_s = sel_found_s | hit_s;
    end
    sel_dur_s = dur_i[int'(sel_idx_s)*DUR_W +: DUR_W];
  end

`ifdef TIMER_ARB_ABORT_EN
  // Owner withdrawing its request while counting cuts the interval short.
  always_comb begin
    abort_s = (state_q == ST_COUNT) && !req_i[owner_q];
  end
`else
  // Without the abort feature, a granted interval always runs to completion.
  always_comb begin
    abort_s = 1'b0;
  end
`endif

  // Next-state logic for the IDLE -> COUNT -> DONE sequence and the timer.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    per_d   = per_q;
    pre_d   = pre_q;
    grant_d = grant_q;
    done_d  = {N_REQ{1'b0}};
    case (state_q)
      ST_IDLE: begin
        grant_d = {N_REQ{1'b0}};
        if (sel_found_s) begin
          state_d = ST_COUNT;
          owner_d = sel_idx_s;
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx_s;
          // Period counter holds the number of remaining periods minus one.
          per_d   = (sel_dur_s == {DUR_W{1'b0}}) ? {DUR_W{1'b0}}
                                                 : sel_dur_s - {{(DUR_W-1){1'b0}}, 1'b1};
          pre_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (abort_s) begin
          state_d = ST_IDLE;
          grant_d = {N_REQ{1'b0}};
          last_d  = owner_q;
          pre_d   = {CNT_W{1'b0}};
          per_d   = {DUR_W{1'b0}};
        end else if (pre_q == PRE_LAST) begin
          pre_d = {CNT_W{1'b0}};
          if (per_q == {DUR_W{1'b0}}) begin
            state_d = ST_DONE;
            done_d  = grant_q;
          end else begin
            per_d = per_q - {{(DUR_W-1){1'b0}}, 1'b1};
          end
        end else begin
          pre_d = pre_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        last_d  = owner_q;
        grant_d = {N_REQ{1'b0}};
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = {N_REQ{1'b0}};
      end
    endcase
  end

  // State, timer and registered-output flops with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= {IDX_W{1'b0}};
      last_q  <= IDX_LAST;
      per_q   <= {DUR_W{1'b0}};
      pre_q   <= {CNT_W{1'b0}};
      grant_q <= {N_REQ{1'b0}};
      done_q  <= {N_REQ{1'b0}};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      per_q   <= per_d;
      pre_q   <= pre_d;
      grant_q <= grant_d;
      done_q  <= done_d;
    end
  end

  assign grant_o  = grant_q;
  assign done_o   = done_q;
  assign active_o = (state_q == ST_COUNT);
  assign busy_o   = (state_q == ST_COUNT) || (state_q == ST_DONE);

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter (N_REQ=4, TICK_MAX=4, DUR_W=3, CNT_W=3).
// Stimulus pushes the expected {owner, active length} of each interval; a
// negedge monitor pops an entry whenever done is presented and compares.
module tb_timer_arbiter;

  localparam int N_REQ    = 4;
  localparam int CNT_W    = 3;
  localparam int TICK_MAX = 4;
  localparam int DUR_W    = 3;

  logic                   clk_i;
  logic                   rst_i;
  logic [N_REQ-1:0]       req_i;
  logic [N_REQ*DUR_W-1:0] dur_i;
  logic [N_REQ-1:0]       grant_o;
  logic                   active_o;
  logic [N_REQ-1:0]       done_o;
  logic                   busy_o;

  typedef struct {
    logic [N_REQ-1:0] owner;
    int               len;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec;
  int   n_err;
  int   act_len;

  timer_arbiter #(
    .N_REQ   (N_REQ),
    .CNT_W   (CNT_W),
    .TICK_MAX(TICK_MAX),
    .DUR_W   (DUR_W)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .dur_i   (dur_i),
    .grant_o (grant_o),
    .active_o(active_o),
    .done_o  (done_o),
    .busy_o  (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [N_REQ-1:0] owner, input int len);
    exp_t e;
    e.owner = owner;
    e.len   = len;
    sb_q.push_back(e);
  endtask

  task automatic set_dur(input int idx, input logic [DUR_W-1:0] v);
    dur_i[idx*DUR_W +: DUR_W] = v;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (done_o == 4'b0000 && n < 200);
    check(name, {31'd0, done_o != 4'b0000}, 32'd1);
  endtask

  // Monitor: measure active length and score every done pulse.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) begin
      act_len = 0;
    end else if (done_o != 4'b0000) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", {28'd0, done_o}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("done_owner", {28'd0, done_o}, {28'd0, e.owner});
        check("grant_in_done", {28'd0, grant_o}, {28'd0, e.owner});
        check("active_len", act_len, e.len);
        check("active_in_done", {31'd0, active_o}, 32'd0);
      end
      act_len = 0;
    end else if (active_o) begin
      act_len++;
    end else begin
      act_len = 0;
    end
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    act_len = 0;
    rst_i   = 1'b1;
    req_i   = 4'b0000;
    dur_i   = 12'd0;

    // Test 1: reset state
    tick();
    check("rst_grant", {28'd0, grant_o}, 32'd0);
    check("rst_done", {28'd0, done_o}, 32'd0);
    check("rst_active", {31'd0, active_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    tick();
    rst_i = 1'b0;

    // Test 2: single request, dur0=2 -> 8 active cycles
    set_dur(0, 3'd2);
    req_i = 4'b0001;
    push(4'b0001, 8);
    tick();
    check("t2_grant_c1", {28'd0, grant_o}, 32'h1);
    check("t2_active_c1", {31'd0, active_o}, 32'd1);
    repeat (7) tick();
    check("t2_active_c8", {31'd0, active_o}, 32'd1);
    tick();
    check("t2_done_c9", {28'd0, done_o}, 32'h1);
    check("t2_busy_c9", {31'd0, busy_o}, 32'd1);
    req_i = 4'b0000;
    tick();
    check("t2_grant_c10", {28'd0, grant_o}, 32'd0);
    check("t2_busy_c10", {31'd0, busy_o}, 32'd0);
    repeat (3) tick();
    check("t2_sb_empty", sb_q.size(), 32'd0);

    // Test 3: contention req=1010, all dur=1 -> owners 1,3,1,3
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    dur_i = 12'b001_001_001_001;
    push(4'b0010, 4);
    push(4'b1000, 4);
    push(4'b0010, 4);
    push(4'b1000, 4);
    req_i = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      wait_done("t3_done_seen");
      if (i == 3) begin
        req_i = 4'b0000;
      end else begin
        tick();
        check("t3_gap_idle", {27'd0, active_o, grant_o}, 32'd0);
        tick();
        check("t3_gap_resume", {31'd0, active_o}, 32'd1);
      end
    end
    repeat (3) tick();
    check("t3_sb_empty", sb_q.size(), 32'd0);

    // Test 5: reset in cycle 5 of a dur=2 interval, then full restart
    set_dur(0, 3'd2);
    req_i = 4'b0001;
    tick();
    repeat (4) tick();
    rst_i = 1'b1;
    #1;
    check("t5_rst_grant", {28'd0, grant_o}, 32'd0);
    check("t5_rst_active", {31'd0, active_o}, 32'd0);
    check("t5_rst_busy", {31'd0, busy_o}, 32'd0);
    check("t5_rst_done", {28'd0, done_o}, 32'd0);
    push(4'b0001, 8);
    tick();
    rst_i = 1'b0;
    wait_done("t5_done_seen");
    req_i = 4'b0000;
    repeat (3) tick();
    check("t5_sb_empty", sb_q.size(), 32'd0);

    // Test 4: zero duration counts as one period
    set_dur(2, 3'd0);
    req_i = 4'b0100;
    push(4'b0100, 4);
    wait_done("t4_done_seen");
    req_i = 4'b0000;
    repeat (3) tick();
    check("t4_sb_empty", sb_q.size(), 32'd0);

    // Test 6: owner drops req in cycle 3 of a dur=3 interval
    set_dur(0, 3'd3);
`ifndef TIMER_ARB_ABORT_EN
    push(4'b0001, 12);
`endif
    req_i = 4'b0001;
    tick();
    tick();
    tick();
    req_i = 4'b0000;
    tick();
`ifdef TIMER_ARB_ABORT_EN
    check("t6_abort_active", {31'd0, active_o}, 32'd0);
    check("t6_abort_grant", {28'd0, grant_o}, 32'd0);
    repeat (20) tick();
`else
    check("t6_keep_active", {31'd0, active_o}, 32'd1);
    wait_done("t6_done_seen");
    repeat (3) tick();
`endif
    check("t6_sb_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
